// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: assembles 32-bit words from four byte reads
// on the shared memory port and presents them to the IF/ID boundary.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [4:0]  stall_cmd,
  input  logic        br_en,
  input  logic [31:0] br_target,
  input  logic        mem_gnt,
  input  logic [7:0]  mem_din,
  output logic [31:0] mem_addr,
  output logic        mem_rd_en,
  output logic        if_stall_req,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        if_valid
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] buf_q, buf_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        if_valid_q, if_valid_d;

  logic        start;
  logic        load;
  logic [31:0] ld_word;
  logic [31:0] word;
  logic        pc_hold;
  logic        id_hold;
  logic        unused_stall;

  assign pc_hold      = stall_cmd[0];
  assign id_hold      = stall_cmd[1];
  assign unused_stall = ^stall_cmd[4:2];

  assign if_pc    = if_pc_q;
  assign if_inst  = if_inst_q;
  assign if_valid = if_valid_q;

  always_comb begin
    start = (state_q == IDLE) && mem_gnt && !pc_hold && !br_en;
    word  = {mem_din, buf_q[23:0]};

    mem_addr  = pc_q + {29'b0, cnt_q};
    mem_rd_en = !rst && rdy && !br_en &&
                (start ||
                 ((state_q == FETCH) && (cnt_q != 3'd4)));

    if_stall_req = !rst &&
                   ((state_q == FETCH) ||
                    ((state_q == IDLE) && !mem_gnt && !br_en));
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    buf_d   = buf_q;
    load    = 1'b0;
    ld_word = buf_q;

    if (br_en) begin
      // Redirect aborts any burst; the in-flight byte is dropped.
      pc_d    = br_target;
      cnt_d   = 3'd0;
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            cnt_d   = 3'd1;
            state_d = FETCH;
          end
        end
        FETCH: begin
          unique case (cnt_q)
            3'd1:    buf_d[7:0]   = mem_din;
            3'd2:    buf_d[15:8]  = mem_din;
            3'd3:    buf_d[23:16] = mem_din;
            3'd4:    buf_d[31:24] = mem_din;
            default: buf_d        = buf_q;
          endcase
          if (cnt_q == 3'd4) begin
            if (!id_hold) begin
              load    = 1'b1;
              ld_word = word;
              pc_d    = pc_q + 32'd4;
              cnt_d   = 3'd0;
              state_d = IDLE;
            end else begin
              state_d = HOLD;
            end
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
        HOLD: begin
          if (!id_hold) begin
            load    = 1'b1;
            ld_word = buf_q;
            pc_d    = pc_q + 32'd4;
            cnt_d   = 3'd0;
            state_d = IDLE;
          end
        end
        default: begin
          cnt_d   = 3'd0;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    if_pc_d    = if_pc_q;
    if_inst_d  = if_inst_q;
    if_valid_d = if_valid_q;

    if (br_en) begin
      if_valid_d = 1'b0;
    end else if (load) begin
      if_pc_d    = pc_q;
      if_inst_d  = ld_word;
      if_valid_d = 1'b1;
    end else if (!id_hold) begin
      if_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      pc_q       <= RESET_PC;
      buf_q      <= 32'd0;
      if_pc_q    <= 32'd0;
      if_inst_q  <= 32'd0;
      if_valid_q <= 1'b0;
    end else if (rdy) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pc_q       <= pc_d;
      buf_q      <= buf_d;
      if_pc_q    <= if_pc_d;
      if_inst_q  <= if_inst_d;
      if_valid_q <= if_valid_d;
    end
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage for the RISC-V core; it issues stall requests to, and consumes stall commands from, the pipeline stall controller.
- Reads each 32-bit instruction as four little-endian bytes from the shared byte-wide memory port.
- Drives `if_stall_req` while a fetch is in flight.
- Honours `stall_cmd[0]` (PC hold) and `stall_cmd[1]` (IF/ID hold), and accepts branch redirects from EX.

Parameters:
- RESET_PC, 32'h00000000, PC loaded on reset.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global ready; low freezes the block
- stall_cmd  in  5  from stall controller; [0] holds PC/fetch start, [1] holds IF/ID output regs
- br_en  in  1  redirect request from EX
- br_target  in  32  redirect PC
- mem_gnt  in  1  shared memory port granted to IF this cycle
- mem_din  in  8  read byte; valid the cycle after its address is issued
- mem_addr  out  32  byte address
- mem_rd_en  out  1  read strobe
- if_stall_req  out  1  to stall controller
- if_pc  out  32  PC of presented instruction
- if_inst  out  32  presented instruction
- if_valid  out  1  if_pc/if_inst hold a real instruction

Behaviour:
- Clock, reset and freeze:
  - Everything except `mem_addr`, `mem_rd_en` and `if_stall_req` is registered on the rising edge of `clk`.
  - Reset (synchronous, `rst`=1): pc=RESET_PC, state=IDLE, cnt=0, buf=0, if_pc=0, if_inst=0, if_valid=0. `mem_rd_en`=0 during reset.
  - `rdy`=0 with `rst`=0: no register changes; `mem_rd_en` forced 0. The memory is frozen by the same `rdy`, so bursts resume intact.
- States: IDLE, FETCH, HOLD.
- `mem_addr` = pc + cnt and `mem_rd_en` are combinational from registered state.
- IDLE:
  - Start condition: `mem_gnt`=1 && `stall_cmd[0]`=0 && `br_en`=0.
  - On start: `mem_rd_en`=1, addr=pc (cnt=0); next cnt=1, state=FETCH.
- FETCH (cnt 1..4):
  - Capture `mem_din` into buf byte cnt-1.
  - If cnt<4, issue addr pc+cnt with `mem_rd_en`=1; cnt increments.
  - The arbiter never revokes `mem_gnt` mid-burst, so `mem_gnt` is ignored in FETCH.
- Completion, at the cnt=4 capture:
  - Assembled word = {b3,b2,b1,b0}.
  - If `stall_cmd[1]`=0: load if_inst=word, if_pc=pc, if_valid=1; pc+=4; state=IDLE.
  - If `stall_cmd[1]`=1: state=HOLD, word kept in buf, pc unchanged.
- HOLD: on the first cycle with `stall_cmd[1]`=0, load outputs from buf, pc+=4, state=IDLE.
- Output registers:
  - `stall_cmd[1]`=1: if_pc/if_inst/if_valid hold.
  - `stall_cmd[1]`=0 and no word loads this cycle: if_valid<=0 (bubble); if_pc/if_inst may hold stale values.
- Latency: 5 cycles per instruction from the IDLE issue cycle to if_valid=1, with back-to-back fetches (the next IDLE issue is in the cycle after the load).
- if_stall_req = (state==FETCH) || (state==IDLE && `mem_gnt`=0 && `br_en`=0). It is 0 in HOLD and in reset.
- Redirect, `br_en`=1 in any state:
  - Has highest priority over `stall_cmd`.
  - Aborts any burst; no `mem_rd_en` that cycle.
  - pc<=br_target, cnt<=0, state<=IDLE, if_valid<=0.
  - The byte returning next cycle is discarded.
- No alignment check; `br_target` is used as given. pc arithmetic wraps mod 2^32.
- Simultaneous completion and `br_en`: redirect wins; the word is dropped and pc=br_target.

Test Plan:
- Reset then fetch:
  - Stimulus: RESET_PC=0; memory bytes 0..3 = 93,00,10,00; `mem_gnt`=1; no stalls.
  - Required: addr 0,1,2,3 on consecutive cycles; if_inst=32'h00100093, if_pc=0, if_valid=1 five cycles after the first issue; if_stall_req high in cycles 2-5 of that burst.
  - Required, next instruction: addr 4 issued the following cycle.
- IF/ID stall at completion:
  - Stimulus: `stall_cmd`=5'b00011 during the cnt=4 cycle, held 3 cycles.
  - Required: state HOLD; if_valid/if_inst unchanged; if_stall_req=0; no `mem_rd_en`.
  - Required after release: new word appears one cycle later; pc advances by exactly 4.
- Redirect mid-burst:
  - Stimulus: `br_en`=1, `br_target`=32'h100 at cnt=2.
  - Required: burst aborted; if_valid=0; next issue at addr 32'h100; the first instruction from 32'h100 is correct, with no byte mixing.
- Grant denied:
  - Stimulus: `mem_gnt`=0 for 4 cycles in IDLE.
  - Required: `mem_rd_en`=0 and if_stall_req=1 throughout; fetch starts the cycle `mem_gnt` rises.
- rdy freeze:
  - Stimulus: `rdy`=0 for 2 cycles at cnt=2.
  - Required: all registers constant, `mem_rd_en`=0; the burst completes correctly afterward with an assembled word identical to the unfrozen case.
- Redirect vs completion:
  - Stimulus: `br_en`=1 at cnt=4.
  - Required: if_valid=0; pc=`br_target`; the completed word is never presented.
